// File: rtl/nand_page_responder.sv
// nand_page_responder: NAND target model that decodes host strobes into read, program, status and reset
// operations against a synchronous page memory with ready/busy timing.
module nand_page_responder #(
    parameter int TR_CYCLES    = 8,
    parameter int TPROG_CYCLES = 32,
    parameter int TRST_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cle,
    input  logic        ale,
    input  logic        wen,
    input  logic        ren,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
    output logic        io_oe,
    output logic        rb,
    output logic [17:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        mem_we
);
    typedef enum logic [2:0] {IDLE, ADDR, READ_BUSY, READ_OUT, PROG_DATA, PROG_BUSY, RST_BUSY} state_t;
    state_t state;
    logic wen_q, ren_q, cap_cle, cap_ale, prog_op, prog_full, status;
    logic [7:0] cap_io;
    logic [8:0] column, page;
    logic [1:0] addr_cnt;
    logic [15:0] cnt;
    logic commit, advance, is_cmd, is_addr, is_data;
    assign commit  = wen & ~wen_q;
    assign advance = ren & ~ren_q;
    assign is_cmd  = commit & cap_cle & ~cap_ale;
    assign is_addr = commit & ~cap_cle & cap_ale;
    assign is_data = commit & ~cap_cle & ~cap_ale;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rb <= 1'b1;
            io_oe <= 1'b0;
            io_out <= 8'h00;
            mem_we <= 1'b0;
            mem_addr <= 18'd0;
            mem_wdata <= 8'h00;
            column <= 9'd0;
            page <= 9'd0;
            status <= 1'b0;
            wen_q <= 1'b1;
            ren_q <= 1'b1;
            cap_io <= 8'h00;
            cap_cle <= 1'b0;
            cap_ale <= 1'b0;
            addr_cnt <= 2'd0;
            prog_op <= 1'b0;
            prog_full <= 1'b0;
            cnt <= 16'd0;
        end else begin
            wen_q <= wen;
            ren_q <= ren;
            mem_we <= 1'b0;
            if (!wen) begin
                cap_io <= io_in;
                cap_cle <= cle;
                cap_ale <= ale;
            end
            io_oe <= (state == READ_OUT || status) && !ren && !cle && !ale;
            io_out <= status ? (rb ? 8'hC0 : 8'h80) : mem_rdata;
            // Busy countdown; a command accepted below in the same cycle overrides it.
            if (!rb) begin
                if (cnt == 16'd0) begin
                    rb <= 1'b1;
                    state <= (state == READ_BUSY) ? READ_OUT : IDLE;
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end
            if (is_cmd) begin
                if (cap_io == 8'hFF) begin
                    state <= RST_BUSY;
                    rb <= 1'b0;
                    cnt <= 16'(TRST_CYCLES - 1);
                    column <= 9'd0;
                    page <= 9'd0;
                    mem_addr <= 18'd0;
                    status <= 1'b0;
                end else if (cap_io == 8'h70) begin
                    status <= 1'b1;
                end else if (rb && cap_io inside {8'h00, 8'h01, 8'h80}) begin
                    state <= ADDR;
                    addr_cnt <= 2'd0;
                    prog_op <= cap_io[7];
                    column[8] <= cap_io[0];
                    status <= 1'b0;
                end else if (rb && cap_io == 8'h10 && state == PROG_DATA) begin
                    state <= PROG_BUSY;
                    rb <= 1'b0;
                    cnt <= 16'(TPROG_CYCLES - 1);
                    status <= 1'b0;
                end
            end else if (is_addr && state == ADDR) begin
                addr_cnt <= addr_cnt + 2'd1;
                if (addr_cnt == 2'd0) begin
                    column[7:0] <= cap_io;
                end else if (addr_cnt == 2'd1) begin
                    page[7:0] <= cap_io;
                end else begin
                    page[8] <= cap_io[0];
                    mem_addr <= {cap_io[0], page[7:0], column};
                    prog_full <= 1'b0;
                    state <= prog_op ? PROG_DATA : READ_BUSY;
                    rb <= prog_op;
                    cnt <= 16'(TR_CYCLES - 1);
                end
            end else if (is_data && state == PROG_DATA && !prog_full) begin
                // Column 511 is written once and then the page buffer is closed.
                mem_we <= 1'b1;
                mem_wdata <= cap_io;
                mem_addr <= {page, column};
                if (column == 9'd511) prog_full <= 1'b1;
                else column <= column + 9'd1;
            end else if (advance && state == READ_OUT && !status) begin
                if (column == 9'd511) begin
                    column <= 9'd0;
                    page <= page + 9'd1;
                    mem_addr <= {page + 9'd1, 9'd0};
                    state <= READ_BUSY;
                    rb <= 1'b0;
                    cnt <= 16'(TR_CYCLES - 1);
                end else begin
                    column <= column + 9'd1;
                    mem_addr <= {page, column + 9'd1};
                end
            end
        end
    end
endmodule

// File: tb/tb_nand_page_responder.sv
// tb_nand_page_responder: host-side stimulus against a byte-array page memory and a simple
// address/busy reference model.
module tb_nand_page_responder;
    logic clk = 1'b0, rst = 1'b1, cle = 1'b0, ale = 1'b0, wen = 1'b1, ren = 1'b1;
    logic [7:0] io_in = 8'h00, io_out, mem_rdata, mem_wdata;
    logic io_oe, rb, mem_we;
    logic [17:0] mem_addr;
    logic [7:0] mem [0:262143];
    int w_addr[$];
    logic [7:0] w_data[$];
    int errors = 0, checks = 0, run = 0, last_busy = 0;

    always #5 clk = ~clk;

    nand_page_responder dut (
        .clk(clk), .rst(rst), .cle(cle), .ale(ale), .wen(wen), .ren(ren), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .rb(rb), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we)
    );

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            w_addr.push_back(int'(mem_addr));
            w_data.push_back(mem_wdata);
        end
    end

    // Length of the most recent completed low period of rb, in clock cycles.
    always @(negedge clk) begin
        if (rst) run = 0;
        else if (!rb) run++;
        else if (run != 0) begin
            last_busy = run;
            run = 0;
        end
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic c, input logic a, input logic [7:0] b);
        cle = c; ale = a; io_in = b; wen = 1'b0;
        cycle(2);
        wen = 1'b1; cle = 1'b0; ale = 1'b0;
        cycle(1);
    endtask

    task automatic cmd(input logic [7:0] b);
        bus_write(1'b1, 1'b0, b);
    endtask

    task automatic addr(input logic [7:0] b);
        bus_write(1'b0, 1'b1, b);
    endtask

    task automatic data(input logic [7:0] b);
        bus_write(1'b0, 1'b0, b);
    endtask

    task automatic read_byte(output logic [7:0] d, output logic oe);
        ren = 1'b0;
        cycle(2);
        d = io_out;
        oe = io_oe;
        ren = 1'b1;
        cycle(2);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rb !== 1'b1 && n < 3000) begin
            cycle(1);
            n++;
        end
        cycle(1);
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL wait_ready: rb=%b still busy after %0d cycles", rb, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(3);
        checks += 5;
        if (rb !== 1'b1) begin errors++; $display("FAIL reset_rb: got %b expected 1", rb); end
        if (io_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", io_oe); end
        if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out: got %h expected 00", io_out); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        if (mem_addr !== 18'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        rst = 1'b0;
        cycle(3);
        checks += 2;
        if (rb !== 1'b1) begin errors++; $display("FAIL release_rb: got %b expected 1", rb); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL release_we: got %b expected 0", mem_we); end
    endtask

    task automatic test_read_basic();
        logic [7:0] d;
        logic oe;
        int base = 261 * 512;
        cmd(8'h00); addr(8'h00); addr(8'h05); addr(8'h01);
        checks++;
        if (rb !== 1'b0) begin errors++; $display("FAIL read_busy_start: rb got %b expected 0", rb); end
        wait_ready();
        checks += 2;
        if (last_busy !== 8) begin errors++; $display("FAIL read_busy_len: got %0d expected 8", last_busy); end
        if (int'(mem_addr) !== base) begin errors++; $display("FAIL read_addr: got %h expected %h", mem_addr, base); end
        for (int i = 0; i < 3; i++) begin
            read_byte(d, oe);
            checks += 2;
            if (d !== mem[base + i]) begin errors++; $display("FAIL read_byte%0d: got %h expected %h", i, d, mem[base + i]); end
            if (oe !== 1'b1) begin errors++; $display("FAIL read_oe%0d: got %b expected 1", i, oe); end
        end
        checks++;
        if (io_oe !== 1'b0) begin errors++; $display("FAIL read_oe_idle: got %b expected 0", io_oe); end
    endtask

    task automatic test_read_upper();
        logic [7:0] d;
        logic oe;
        cmd(8'h01); addr(8'h10); addr(8'h00); addr(8'h00);
        wait_ready();
        read_byte(d, oe);
        checks++;
        if (d !== mem[272]) begin errors++; $display("FAIL read_upper: got %h expected %h", d, mem[272]); end
    endtask

    task automatic test_read_random();
        logic [7:0] d;
        logic oe;
        logic [8:0] pg, cl;
        int base;
        for (int t = 0; t < 4; t++) begin
            pg = 9'($urandom_range(0, 511));
            cl = 9'($urandom_range(0, 500));
            base = int'(pg) * 512 + int'(cl);
            cmd({7'd0, cl[8]}); addr(cl[7:0]); addr(pg[7:0]); addr({7'($urandom), pg[8]});
            wait_ready();
            checks++;
            if (last_busy !== 8) begin errors++; $display("FAIL rand_busy%0d: got %0d expected 8", t, last_busy); end
            for (int i = 0; i < 3; i++) begin
                read_byte(d, oe);
                checks++;
                if (d !== mem[base + i]) begin errors++; $display("FAIL rand_read%0d_%0d: got %h expected %h", t, i, d, mem[base + i]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic oe;
        int base = 511 * 512 + 510;
        cmd(8'h01); addr(8'hFE); addr(8'hFF); addr(8'h01);
        wait_ready();
        for (int i = 0; i < 2; i++) begin
            read_byte(d, oe);
            checks++;
            if (d !== mem[base + i]) begin errors++; $display("FAIL wrap_read%0d: got %h expected %h", i, d, mem[base + i]); end
        end
        checks++;
        if (rb !== 1'b0) begin errors++; $display("FAIL wrap_busy_start: rb got %b expected 0", rb); end
        wait_ready();
        checks += 2;
        if (last_busy !== 8) begin errors++; $display("FAIL wrap_busy_len: got %0d expected 8", last_busy); end
        if (mem_addr !== 18'd0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", mem_addr); end
        read_byte(d, oe);
        checks++;
        if (d !== mem[0]) begin errors++; $display("FAIL wrap_page0: got %h expected %h", d, mem[0]); end
    endtask

    task automatic test_program();
        logic [7:0] d;
        logic oe;
        w_addr.delete(); w_data.delete();
        cmd(8'h80); addr(8'h00); addr(8'h07); addr(8'h00);
        data(8'hAA); data(8'h55);
        cmd(8'h10);
        checks++;
        if (rb !== 1'b0) begin errors++; $display("FAIL prog_busy_start: rb got %b expected 0", rb); end
        cmd(8'h70);
        read_byte(d, oe);
        checks += 2;
        if (d !== 8'h80) begin errors++; $display("FAIL status_busy: got %h expected 80", d); end
        if (oe !== 1'b1) begin errors++; $display("FAIL status_oe: got %b expected 1", oe); end
        wait_ready();
        checks++;
        if (last_busy !== 32) begin errors++; $display("FAIL prog_busy_len: got %0d expected 32", last_busy); end
        read_byte(d, oe);
        checks++;
        if (d !== 8'hC0) begin errors++; $display("FAIL status_ready: got %h expected C0", d); end
        checks += 5;
        if (w_addr.size() !== 2) begin errors++; $display("FAIL prog_count: got %0d expected 2", w_addr.size()); end
        if (w_addr[0] !== 7 * 512) begin errors++; $display("FAIL prog_addr0: got %h expected %h", w_addr[0], 7 * 512); end
        if (w_data[0] !== 8'hAA) begin errors++; $display("FAIL prog_data0: got %h expected AA", w_data[0]); end
        if (w_addr[1] !== 7 * 512 + 1) begin errors++; $display("FAIL prog_addr1: got %h expected %h", w_addr[1], 7 * 512 + 1); end
        if (w_data[1] !== 8'h55) begin errors++; $display("FAIL prog_data1: got %h expected 55", w_data[1]); end
    endtask

    task automatic test_prog_reset();
        logic [8:0] pg = 9'($urandom_range(0, 511));
        logic [7:0] cl = 8'($urandom), d1 = 8'($urandom);
        w_addr.delete(); w_data.delete();
        cmd(8'h80); addr(cl); addr(pg[7:0]); addr({7'd0, pg[8]});
        data(d1);
        cmd(8'hFF);
        data(8'($urandom));
        wait_ready();
        checks++;
        if (last_busy !== 4) begin errors++; $display("FAIL ffh_busy_len: got %0d expected 4", last_busy); end
        data(8'($urandom));
        cmd(8'h10);
        checks++;
        if (rb !== 1'b1) begin errors++; $display("FAIL ffh_confirm_ignored: rb got %b expected 1", rb); end
        cycle(3);
        checks += 3;
        if (w_addr.size() !== 1) begin errors++; $display("FAIL ffh_write_count: got %0d expected 1", w_addr.size()); end
        if (w_addr[0] !== int'(pg) * 512 + int'(cl)) begin errors++; $display("FAIL ffh_addr: got %h expected %h", w_addr[0], int'(pg) * 512 + int'(cl)); end
        if (w_data[0] !== d1) begin errors++; $display("FAIL ffh_data: got %h expected %h", w_data[0], d1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[260];
        logic [8:0] pg = 9'($urandom_range(0, 511));
        int base = int'(pg) * 512;
        cmd(8'hFF);
        cmd(8'hFF);
        wait_ready();
        checks++;
        if (last_busy !== 7) begin errors++; $display("FAIL ffh_restart_len: got %0d expected 7", last_busy); end
        w_addr.delete(); w_data.delete();
        cmd(8'h80); addr(8'hFF); addr(pg[7:0]); addr({7'd0, pg[8]});
        for (int i = 0; i < 260; i++) begin
            exp_d[i] = 8'($urandom);
            data(exp_d[i]);
        end
        checks += 5;
        if (w_addr.size() !== 257) begin errors++; $display("FAIL col511_count: got %0d expected 257", w_addr.size()); end
        if (w_addr[0] !== base + 255) begin errors++; $display("FAIL col511_first: got %h expected %h", w_addr[0], base + 255); end
        if (w_addr[256] !== base + 511) begin errors++; $display("FAIL col511_last_addr: got %h expected %h", w_addr[256], base + 511); end
        if (w_data[256] !== exp_d[256]) begin errors++; $display("FAIL col511_last_data: got %h expected %h", w_data[256], exp_d[256]); end
        if (w_data[100] !== exp_d[100]) begin errors++; $display("FAIL col511_mid_data: got %h expected %h", w_data[100], exp_d[100]); end
        cmd(8'h10);
        wait_ready();
        checks++;
        if (last_busy !== 32) begin errors++; $display("FAIL col511_prog_len: got %0d expected 32", last_busy); end
    endtask

    task automatic test_rst_mid();
        cmd(8'h00); addr(8'($urandom)); addr(8'($urandom)); addr(8'h00);
        cycle(2);
        checks++;
        if (rb !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: rb got %b expected 0", rb); end
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        checks += 2;
        if (rb !== 1'b1) begin errors++; $display("FAIL rst_mid_rb: got %b expected 1", rb); end
        if (io_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b expected 0", io_oe); end
        cycle(2);
        cmd(8'h3C);
        addr(8'h00); addr(8'h00); addr(8'h00);
        ren = 1'b0;
        cycle(2);
        checks += 2;
        if (rb !== 1'b1) begin errors++; $display("FAIL bad_cmd_rb: got %b expected 1", rb); end
        if (io_oe !== 1'b0) begin errors++; $display("FAIL bad_cmd_oe: got %b expected 0", io_oe); end
        ren = 1'b1;
        cycle(2);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
        test_reset();
        test_read_basic();
        test_read_upper();
        test_read_random();
        test_wrap();
        test_program();
        test_prog_reset();
        test_back_to_back();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
